// File: rtl/pe_ns_pkg.sv
// Shared types and constants for the PE namespace / instruction sequencer slice.
package pe_ns_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RESTART = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_t;

  localparam int END_MARKER = 0;
  localparam int ITER_W     = 16;

  // A repetition count of zero runs the program once.
  function automatic logic [ITER_W-1:0] norm_iter(input logic [ITER_W-1:0] n);
    return (n == '0) ? ITER_W'(1) : n;
  endfunction

endpackage

// File: rtl/pe_namespace_seq_if.sv
// Instruction issue channel between the sequencer and the PE controller.
// Handshake: an instruction is consumed in a cycle where inst_valid=1 and both
// inst_stall and bus_contention are low; otherwise the producer holds
// inst_out/inst_valid/last_inst unchanged.
interface pe_namespace_seq_if #(
  parameter int INST_LEN = 32
) ();
  logic [INST_LEN-1:0] inst_out;
  logic                inst_valid;
  logic                last_inst;
  logic                inst_stall;
  logic                bus_contention;

  modport master (
    output inst_out, inst_valid, last_inst,
    input  inst_stall, bus_contention
  );

  modport slave (
    input  inst_out, inst_valid, last_inst,
    output inst_stall, bus_contention
  );
endinterface

// File: rtl/ns_buffer.sv
// One 1W1R namespace RAM with registered read and optional write-to-read forwarding.
module ns_buffer #(
  parameter int ADDR_LEN = 5,
  parameter int DATA_LEN = 32,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wrt,
  input  logic [ADDR_LEN-1:0] wrt_addr,
  input  logic [DATA_LEN-1:0] wrt_data,
  input  logic [ADDR_LEN-1:0] rd_addr,
  output logic [DATA_LEN-1:0] rd_data
);

  logic [DATA_LEN-1:0] mem [1 << ADDR_LEN];

  // Storage is intentionally not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wrt) mem[wrt_addr] <= wrt_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (BYPASS && wrt && (wrt_addr == rd_addr)) begin
      rd_data <= wrt_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pe_namespace_seq.sv
// PE local namespaces plus a program-counter sequencer over a loadable
// instruction memory with multi-iteration looping and done/busy status.
module pe_namespace_seq
  import pe_ns_pkg::*;
#(
  parameter int INST_ADDR_LEN = 6,
  parameter int INST_LEN      = 32,
  parameter int DATA_LEN      = 32,
  parameter int NUM_NS        = 4,
  parameter int NS_ADDR_LEN   = 5,
  parameter bit BYPASS        = 1'b1,
  parameter int PE_ID         = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ITER_W-1:0]             iter_count,
  input  logic                          inst_load,
  input  logic [INST_ADDR_LEN-1:0]      inst_load_addr,
  input  logic [INST_LEN-1:0]           inst_load_data,
  pe_namespace_seq_if.master            inst_if,
  output logic                          busy,
  output logic                          done,
  input  logic [NUM_NS-1:0]             ns_wrt,
  input  logic [NUM_NS*NS_ADDR_LEN-1:0] ns_wrt_addr,
  input  logic [NUM_NS*DATA_LEN-1:0]    ns_wrt_data,
  input  logic [NUM_NS*NS_ADDR_LEN-1:0] ns_rd_addr,
  output logic [NUM_NS*DATA_LEN-1:0]    ns_rd_data,
  output seq_state_t                    dbg_state,
  output logic [7:0]                    dbg_pe_id
);

  localparam int DEPTH = 1 << INST_ADDR_LEN;

  logic [INST_LEN-1:0]    inst_mem [DEPTH];
  seq_state_t             state_q, state_d;
  // Extra MSB marks "ran off the end of memory" so pc never wraps silently.
  logic [INST_ADDR_LEN:0] pc_q;
  logic [ITER_W-1:0]      iter_left_q;
  logic [INST_LEN-1:0]    inst_out_q;
  logic                   inst_valid_q;
  logic                   last_inst_q;
  logic [INST_LEN-1:0]    fetch_word;
  logic                   adv;
  logic                   launch;
  logic                   fetch_en;
  logic                   end_en;

  assign adv        = ~inst_if.inst_stall & ~inst_if.bus_contention;
  assign fetch_word = pc_q[INST_ADDR_LEN] ? INST_LEN'(END_MARKER)
                                          : inst_mem[pc_q[INST_ADDR_LEN-1:0]];

  always_ff @(posedge clk) begin
    if (inst_load && (state_q == ST_IDLE)) inst_mem[inst_load_addr] <= inst_load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    fetch_en = 1'b0;
    end_en   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          launch  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (adv) begin
          if (last_inst_q) begin
            end_en  = 1'b1;
            state_d = (iter_left_q == ITER_W'(1)) ? ST_DONE : ST_RESTART;
          end else begin
            fetch_en = 1'b1;
          end
        end
      end
      // The bubble cycle fetches word 0 so it appears right after the bubble.
      ST_RESTART: begin
        if (adv) begin
          fetch_en = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      iter_left_q  <= '0;
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
      last_inst_q  <= 1'b0;
    end else if (launch) begin
      pc_q         <= '0;
      iter_left_q  <= norm_iter(iter_count);
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
      last_inst_q  <= 1'b0;
    end else if (fetch_en) begin
      inst_out_q   <= fetch_word;
      inst_valid_q <= (fetch_word != INST_LEN'(END_MARKER));
      last_inst_q  <= (fetch_word == INST_LEN'(END_MARKER));
      if (!pc_q[INST_ADDR_LEN]) pc_q <= pc_q + (INST_ADDR_LEN+1)'(1);
    end else if (end_en) begin
      pc_q         <= '0;
      iter_left_q  <= iter_left_q - ITER_W'(1);
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
      last_inst_q  <= 1'b0;
    end
  end

  assign inst_if.inst_out   = inst_out_q;
  assign inst_if.inst_valid = inst_valid_q;
  assign inst_if.last_inst  = last_inst_q;
  assign dbg_state          = state_q;
  assign dbg_pe_id          = 8'(PE_ID);

  for (genvar i = 0; i < NUM_NS; i++) begin : gen_ns
    ns_buffer #(
      .ADDR_LEN (NS_ADDR_LEN),
      .DATA_LEN (DATA_LEN),
      .BYPASS   (BYPASS)
    ) u_ns_buffer (
      .clk      (clk),
      .reset    (reset),
      .wrt      (ns_wrt[i]),
      .wrt_addr (ns_wrt_addr[i*NS_ADDR_LEN +: NS_ADDR_LEN]),
      .wrt_data (ns_wrt_data[i*DATA_LEN +: DATA_LEN]),
      .rd_addr  (ns_rd_addr[i*NS_ADDR_LEN +: NS_ADDR_LEN]),
      .rd_data  (ns_rd_data[i*DATA_LEN +: DATA_LEN])
    );
  end

endmodule
